// File: rtl/memory2_stage_if.sv
// Pass structs and the memory1/memory2/writeback/dcache bundle used by memory2_stage.
typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        is_wr_rd;
    logic        is_wr_rd_pc_plus4;
    logic        is_ld;
    logic        is_st;
    logic        ld_signed;
    logic [1:0]  ld_size;
    logic [31:0] va;
    logic [31:0] pa;
    logic [31:0] ex_mem_out;
} memory1_memory2_pass_t;

typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        is_wr_rd;
    logic        is_wr_rd_pc_plus4;
    logic [31:0] ex_mem_out;
} memory2_writeback_pass_t;

interface memory2_stage_if;
    logic                    flush_i;
    logic                    stall_i;
    logic                    stall_o;
    memory1_memory2_pass_t   pass_in;
    memory2_writeback_pass_t pass_out;
    logic                    dc_rvalid;
    logic [31:0]             dc_rdata;
    logic                    fwd_valid;
    logic [4:0]              fwd_rd;
    logic [31:0]             fwd_data;

    modport master (
        output flush_i, stall_i, pass_in, dc_rvalid, dc_rdata,
        input  stall_o, pass_out, fwd_valid, fwd_rd, fwd_data
    );

    modport slave (
        input  flush_i, stall_i, pass_in, dc_rvalid, dc_rdata,
        output stall_o, pass_out, fwd_valid, fwd_rd, fwd_data
    );
endinterface

// File: rtl/memory2_stage.sv
// Second memory stage: waits for the dcache load response, aligns/extends it, drains flushed responses.
// Optional bypass port enabled by defining MEM2_FWD_EN; otherwise fwd_* are tied to zero.
module memory2_stage #(
    parameter int DRAIN_CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    memory2_stage_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_MAX = '1;
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_ONE = DRAIN_CNT_W'(1);

    memory1_memory2_pass_t  pass_q;
    state_t                 state_q;
    logic [DRAIN_CNT_W-1:0] drain_cnt_q;
    logic [DRAIN_CNT_W-1:0] drain_cnt_d;
    logic [31:0]            hold_data_q;

    logic        is_load;
    logic        drain_zero;
    logic        wait_phase;
    logic        hold_phase;
    logic        resp_hit;
    logic        orphan;
    logic        load_open;
    logic        stall;
    logic [31:0] ld_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_result;
    logic [31:0] result;
    logic        unused_fields;

    assign is_load    = pass_q.valid & pass_q.is_ld;
    assign drain_zero = (drain_cnt_q == '0);
    // A load sitting in IDLE with no orphans outstanding is treated exactly like WAIT,
    // so a response in the very first cycle is taken without a bubble.
    assign wait_phase = is_load & (((state_q == S_IDLE) & drain_zero) | (state_q == S_WAIT));
    assign hold_phase = is_load & (state_q == S_HOLD);
    assign resp_hit   = wait_phase & bus.dc_rvalid;
    assign orphan     = bus.dc_rvalid & ~drain_zero;
    // The load's own response is still in flight; a flush now turns it into an orphan.
    assign load_open  = is_load & (state_q != S_HOLD) & ~resp_hit;

    always_comb begin
        stall = bus.stall_i;
        if (is_load) begin
            if (wait_phase) begin
                stall = ~bus.dc_rvalid | bus.stall_i;
            end else if (!hold_phase) begin
                stall = 1'b1;
            end
        end
    end

    always_comb begin
        drain_cnt_d = drain_cnt_q;
        if (orphan) begin
            drain_cnt_d = drain_cnt_d - DRAIN_ONE;
        end
        if (bus.flush_i && load_open) begin
            drain_cnt_d = drain_cnt_d + DRAIN_ONE;
        end
    end

    assign ld_word = hold_phase ? hold_data_q : bus.dc_rdata;
    assign ld_byte = ld_word[{pass_q.va[1:0], 3'b000} +: 8];
    assign ld_half = ld_word[{pass_q.va[1], 4'b0000} +: 16];

    always_comb begin
        case (pass_q.ld_size)
            2'd0:    ld_result = {{24{pass_q.ld_signed & ld_byte[7]}}, ld_byte};
            2'd1:    ld_result = {{16{pass_q.ld_signed & ld_half[15]}}, ld_half};
            default: ld_result = ld_word;
        endcase
    end

    assign result = pass_q.is_ld ? ld_result : pass_q.ex_mem_out;

    always_comb begin
        bus.pass_out                   = '0;
        bus.pass_out.valid             = pass_q.valid & ~stall & ~bus.flush_i;
        bus.pass_out.pc                = pass_q.pc;
        bus.pass_out.inst              = pass_q.inst;
        bus.pass_out.rd                = pass_q.rd;
        bus.pass_out.is_wr_rd          = pass_q.is_wr_rd;
        bus.pass_out.is_wr_rd_pc_plus4 = pass_q.is_wr_rd_pc_plus4;
        bus.pass_out.ex_mem_out        = result;
    end

    assign bus.stall_o = stall;

`ifdef MEM2_FWD_EN
    logic data_ready;
    assign data_ready    = resp_hit | hold_phase;
    assign bus.fwd_valid = pass_q.valid & pass_q.is_wr_rd & ~stall & (~pass_q.is_ld | data_ready);
    assign bus.fwd_rd    = pass_q.rd;
    assign bus.fwd_data  = pass_q.is_wr_rd_pc_plus4 ? (pass_q.pc + 32'd4) : result;
`else
    assign bus.fwd_valid = 1'b0;
    assign bus.fwd_rd    = '0;
    assign bus.fwd_data  = '0;
`endif

    assign unused_fields = ^{pass_q.is_st, pass_q.pa, pass_q.va[31:2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q      <= '0;
            state_q     <= S_IDLE;
            drain_cnt_q <= '0;
            hold_data_q <= '0;
        end else begin
            if (!stall || bus.flush_i) begin
                pass_q       <= bus.pass_in;
                pass_q.valid <= bus.pass_in.valid & ~bus.flush_i;
            end
            drain_cnt_q <= drain_cnt_d;
            if (bus.flush_i) begin
                state_q     <= S_IDLE;
                hold_data_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE, S_WAIT: begin
                        if (!wait_phase) begin
                            state_q <= S_IDLE;
                        end else if (!bus.dc_rvalid) begin
                            state_q <= S_WAIT;
                        end else if (bus.stall_i) begin
                            state_q     <= S_HOLD;
                            hold_data_q <= bus.dc_rdata;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                    S_HOLD:  state_q <= bus.stall_i ? S_HOLD : S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    a_drain_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.flush_i && load_open && !orphan && (drain_cnt_q == DRAIN_MAX)));
    a_no_stray_response: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.dc_rvalid && drain_zero && !wait_phase));
endmodule

// File: tb/tb_memory2_stage.sv
// Scoreboard bench for memory2_stage: expected writeback results are queued at issue, popped on pass_out.valid.
module tb_memory2_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    memory2_stage_if bus ();
    memory2_stage #(.DRAIN_CNT_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q [$];
    logic [63:0] exp;
    logic [37:0] exp_fwd;

    function automatic memory1_memory2_pass_t mk_ld(input logic [31:0] pc, input logic [31:0] va,
                                                   input logic sgn, input logic [1:0] sz);
        memory1_memory2_pass_t p;
        p            = '0;
        p.valid      = 1'b1;
        p.pc         = pc;
        p.inst       = 32'h0000_0003;
        p.rd         = 5'd7;
        p.is_wr_rd   = 1'b1;
        p.is_ld      = 1'b1;
        p.ld_signed  = sgn;
        p.ld_size    = sz;
        p.va         = va;
        p.pa         = va;
        p.ex_mem_out = va;
        return p;
    endfunction

    function automatic memory1_memory2_pass_t mk_alu(input logic [31:0] pc, input logic [4:0] rd,
                                                    input logic [31:0] res, input logic pcp4);
        memory1_memory2_pass_t p;
        p                   = '0;
        p.valid             = 1'b1;
        p.pc                = pc;
        p.inst              = 32'h0000_0033;
        p.rd                = rd;
        p.is_wr_rd          = 1'b1;
        p.is_wr_rd_pc_plus4 = pcp4;
        p.ex_mem_out        = res;
        return p;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.pass_in   = '0;
        bus.flush_i   = 1'b0;
        bus.stall_i   = 1'b0;
        bus.dc_rvalid = 1'b0;
        bus.dc_rdata  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #3;
        n_tests++;
        if (bus.stall_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall_o);
        end
        n_tests++;
        if (bus.pass_out.valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", bus.pass_out.valid);
        end
        n_tests++;
        if ({bus.fwd_valid, bus.fwd_rd, bus.fwd_data} !== 38'h0) begin
            n_fail++; $display("FAIL reset_fwd: got %b/%h/%h want 0/0/0", bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
        end
    endtask

    // ld.b at byte 3 with the response two cycles late.
    task automatic test_ld_byte();
        cyc();
        bus.pass_in = mk_ld(32'h100, 32'h0000_1003, 1'b1, 2'd0);
        exp_q.push_back({32'h100, 32'hFFFF_FF80});
        cyc();
        bus.pass_in = '0;
        for (int i = 0; i < 2; i++) begin
            #3;
            n_tests++;
            if (bus.stall_o !== 1'b1 || bus.pass_out.valid !== 1'b0) begin
                n_fail++; $display("FAIL ld_b_wait%0d: stall=%b valid=%b want 1/0", i, bus.stall_o, bus.pass_out.valid);
            end
            cyc();
        end
        bus.dc_rvalid = 1'b1;
        bus.dc_rdata  = 32'h80FF_1234;
        #3;
        n_tests++;
        if (bus.stall_o !== 1'b0) begin
            n_fail++; $display("FAIL ld_b_release: stall got %b want 0", bus.stall_o);
        end
        exp = '1;
        if (exp_q.size() != 0) exp = exp_q.pop_front();
        n_tests++;
        if (bus.pass_out.valid !== 1'b1 || {bus.pass_out.pc, bus.pass_out.ex_mem_out} !== exp) begin
            n_fail++; $display("FAIL ld_b_out: got v=%b pc=%h data=%h want pc=%h data=%h",
                               bus.pass_out.valid, bus.pass_out.pc, bus.pass_out.ex_mem_out, exp[63:32], exp[31:0]);
        end
        cyc();
        drive_idle();
    endtask

    // Back-to-back loads, each answered in its first cycle; covers every size/offset/sign case.
    task automatic test_load_align();
        logic [1:0]  t_va  [8] = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd2};
        logic [1:0]  t_sz  [8] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd0};
        logic        t_sg  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] t_rd  [8] = '{32'h80FF_1234, 32'hBEEF_0001, 32'h1234_5687, 32'h1234_5687,
                                   32'h8001_0000, 32'h0000_F00D, 32'hDEAD_BEEF, 32'h007F_0000};
        logic [31:0] t_exp [8] = '{32'hFFFF_FF80, 32'h0000_BEEF, 32'hFFFF_FF87, 32'h0000_0056,
                                   32'hFFFF_8001, 32'h0000_F00D, 32'hDEAD_BEEF, 32'h0000_007F};
        for (int i = 0; i <= 8; i++) begin
            cyc();
            bus.dc_rvalid = 1'b0;
            if (i < 8) begin
                bus.pass_in = mk_ld(32'h1000 + 32'(4 * i), {28'h0000_200, 2'b00, t_va[i]}, t_sg[i], t_sz[i]);
                exp_q.push_back({32'h1000 + 32'(4 * i), t_exp[i]});
            end else begin
                bus.pass_in = '0;
            end
            if (i > 0) begin
                bus.dc_rvalid = 1'b1;
                bus.dc_rdata  = t_rd[i-1];
                #3;
                n_tests++;
                if (bus.stall_o !== 1'b0) begin
                    n_fail++; $display("FAIL align%0d_stall: got %b want 0", i - 1, bus.stall_o);
                end
                exp = '1;
                if (exp_q.size() != 0) exp = exp_q.pop_front();
                n_tests++;
                if (bus.pass_out.valid !== 1'b1 || {bus.pass_out.pc, bus.pass_out.ex_mem_out} !== exp) begin
                    n_fail++; $display("FAIL align%0d_out: got v=%b pc=%h data=%h want pc=%h data=%h", i - 1,
                                       bus.pass_out.valid, bus.pass_out.pc, bus.pass_out.ex_mem_out, exp[63:32], exp[31:0]);
                end
            end
        end
        cyc();
        drive_idle();
    endtask

    task automatic test_hold();
        cyc();
        bus.pass_in = mk_ld(32'h200, 32'h0000_3000, 1'b0, 2'd2);
        exp_q.push_back({32'h200, 32'hCAFE_F00D});
        cyc();
        bus.pass_in   = '0;
        bus.dc_rvalid = 1'b1;
        bus.dc_rdata  = 32'hCAFE_F00D;
        bus.stall_i   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            n_tests++;
            if (bus.stall_o !== 1'b1 || bus.pass_out.valid !== 1'b0) begin
                n_fail++; $display("FAIL hold_stall%0d: stall=%b valid=%b want 1/0", i, bus.stall_o, bus.pass_out.valid);
            end
            cyc();
            bus.dc_rvalid = 1'b0;
            bus.dc_rdata  = '0;
        end
        bus.stall_i = 1'b0;
        #3;
        exp = '1;
        if (exp_q.size() != 0) exp = exp_q.pop_front();
        n_tests++;
        if (bus.stall_o !== 1'b0 || bus.pass_out.valid !== 1'b1 || {bus.pass_out.pc, bus.pass_out.ex_mem_out} !== exp) begin
            n_fail++; $display("FAIL hold_out: got s=%b v=%b pc=%h data=%h want pc=%h data=%h", bus.stall_o,
                               bus.pass_out.valid, bus.pass_out.pc, bus.pass_out.ex_mem_out, exp[63:32], exp[31:0]);
        end
        cyc();
        #3;
        n_tests++;
        if (bus.pass_out.valid !== 1'b0) begin
            n_fail++; $display("FAIL hold_once: valid got %b want 0", bus.pass_out.valid);
        end
        // Flush while holding: the held word is dropped and the next load is unaffected.
        cyc();
        bus.pass_in = mk_ld(32'h210, 32'h0000_3010, 1'b0, 2'd2);
        cyc();
        bus.pass_in   = '0;
        bus.dc_rvalid = 1'b1;
        bus.dc_rdata  = 32'h1111_1111;
        bus.stall_i   = 1'b1;
        cyc();
        bus.dc_rvalid = 1'b0;
        bus.flush_i   = 1'b1;
        #3;
        n_tests++;
        if (bus.pass_out.valid !== 1'b0) begin
            n_fail++; $display("FAIL hold_flush: valid got %b want 0", bus.pass_out.valid);
        end
        cyc();
        bus.flush_i = 1'b0;
        bus.stall_i = 1'b0;
        bus.pass_in = mk_ld(32'h220, 32'h0000_3001, 1'b0, 2'd0);
        exp_q.push_back({32'h220, 32'h0000_00AB});
        cyc();
        bus.pass_in   = '0;
        bus.dc_rvalid = 1'b1;
        bus.dc_rdata  = 32'h0000_AB00;
        #3;
        exp = '1;
        if (exp_q.size() != 0) exp = exp_q.pop_front();
        n_tests++;
        if (bus.stall_o !== 1'b0 || bus.pass_out.valid !== 1'b1 || {bus.pass_out.pc, bus.pass_out.ex_mem_out} !== exp) begin
            n_fail++; $display("FAIL hold_after_flush: got s=%b v=%b pc=%h data=%h want pc=%h data=%h", bus.stall_o,
                               bus.pass_out.valid, bus.pass_out.pc, bus.pass_out.ex_mem_out, exp[63:32], exp[31:0]);
        end
        cyc();
        drive_idle();
    endtask

    task automatic test_flush_drain();
        cyc();
        bus.pass_in = mk_ld(32'h300, 32'h0000_4000, 1'b0, 2'd2);
        cyc();
        bus.pass_in = '0;
        bus.flush_i = 1'b1;
        #3;
        n_tests++;
        if (bus.stall_o !== 1'b1 || bus.pass_out.valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_flush: stall=%b valid=%b want 1/0", bus.stall_o, bus.pass_out.valid);
        end
        cyc();
        bus.flush_i = 1'b0;
        bus.pass_in = mk_ld(32'h304, 32'h0000_4004, 1'b0, 2'd2);
        exp_q.push_back({32'h304, 32'h600D_F00D});
        cyc();
        bus.pass_in   = '0;
        bus.dc_rvalid = 1'b1;
        bus.dc_rdata  = 32'hBAD0_BAD0;
        #3;
        n_tests++;
        if (bus.stall_o !== 1'b1 || bus.pass_out.valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_orphan: stall=%b valid=%b data=%h want 1/0", bus.stall_o,
                               bus.pass_out.valid, bus.pass_out.ex_mem_out);
        end
        cyc();
        bus.dc_rvalid = 1'b0;
        #3;
        n_tests++;
        if (bus.stall_o !== 1'b1 || bus.pass_out.valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_wait: stall=%b valid=%b want 1/0", bus.stall_o, bus.pass_out.valid);
        end
        cyc();
        bus.dc_rvalid = 1'b1;
        bus.dc_rdata  = 32'h600D_F00D;
        #3;
        exp = '1;
        if (exp_q.size() != 0) exp = exp_q.pop_front();
        n_tests++;
        if (bus.stall_o !== 1'b0 || bus.pass_out.valid !== 1'b1 || {bus.pass_out.pc, bus.pass_out.ex_mem_out} !== exp) begin
            n_fail++; $display("FAIL drain_out: got s=%b v=%b pc=%h data=%h want pc=%h data=%h", bus.stall_o,
                               bus.pass_out.valid, bus.pass_out.pc, bus.pass_out.ex_mem_out, exp[63:32], exp[31:0]);
        end
        cyc();
        drive_idle();
    endtask

    task automatic test_fwd();
        cyc();
        bus.pass_in = mk_alu(32'h400, 5'd5, 32'h0000_1234, 1'b0);
        exp_q.push_back({32'h400, 32'h0000_1234});
        cyc();
        bus.pass_in = mk_alu(32'h500, 5'd1, 32'h0000_0BAD, 1'b1);
        exp_q.push_back({32'h500, 32'h0000_0BAD});
        #3;
        exp = '1;
        if (exp_q.size() != 0) exp = exp_q.pop_front();
        n_tests++;
        if (bus.pass_out.valid !== 1'b1 || {bus.pass_out.pc, bus.pass_out.ex_mem_out} !== exp) begin
            n_fail++; $display("FAIL add_out: got v=%b pc=%h data=%h want pc=%h data=%h",
                               bus.pass_out.valid, bus.pass_out.pc, bus.pass_out.ex_mem_out, exp[63:32], exp[31:0]);
        end
`ifdef MEM2_FWD_EN
        exp_fwd = {1'b1, 5'd5, 32'h0000_1234};
`else
        exp_fwd = '0;
`endif
        n_tests++;
        if ({bus.fwd_valid, bus.fwd_rd, bus.fwd_data} !== exp_fwd) begin
            n_fail++; $display("FAIL add_fwd: got %b/%0d/%h want %b/%0d/%h", bus.fwd_valid, bus.fwd_rd,
                               bus.fwd_data, exp_fwd[37], exp_fwd[36:32], exp_fwd[31:0]);
        end
        cyc();
        bus.pass_in = '0;
        #3;
        exp = '1;
        if (exp_q.size() != 0) exp = exp_q.pop_front();
        n_tests++;
        if (bus.pass_out.valid !== 1'b1 || {bus.pass_out.pc, bus.pass_out.ex_mem_out} !== exp) begin
            n_fail++; $display("FAIL jal_out: got v=%b pc=%h data=%h want pc=%h data=%h",
                               bus.pass_out.valid, bus.pass_out.pc, bus.pass_out.ex_mem_out, exp[63:32], exp[31:0]);
        end
`ifdef MEM2_FWD_EN
        exp_fwd = {1'b1, 5'd1, 32'h0000_0504};
`else
        exp_fwd = '0;
`endif
        n_tests++;
        if ({bus.fwd_valid, bus.fwd_rd, bus.fwd_data} !== exp_fwd) begin
            n_fail++; $display("FAIL jal_fwd: got %b/%0d/%h want %b/%0d/%h", bus.fwd_valid, bus.fwd_rd,
                               bus.fwd_data, exp_fwd[37], exp_fwd[36:32], exp_fwd[31:0]);
        end
        // Downstream stall on a non-load passes straight through.
        cyc();
        bus.pass_in = mk_alu(32'h600, 5'd9, 32'h0000_0077, 1'b0);
        exp_q.push_back({32'h600, 32'h0000_0077});
        cyc();
        bus.pass_in = '0;
        bus.stall_i = 1'b1;
        #3;
        n_tests++;
        if (bus.stall_o !== 1'b1 || bus.pass_out.valid !== 1'b0 || bus.fwd_valid !== 1'b0) begin
            n_fail++; $display("FAIL alu_stall: stall=%b valid=%b fwd=%b want 1/0/0", bus.stall_o,
                               bus.pass_out.valid, bus.fwd_valid);
        end
        cyc();
        bus.stall_i = 1'b0;
        #3;
        exp = '1;
        if (exp_q.size() != 0) exp = exp_q.pop_front();
        n_tests++;
        if (bus.stall_o !== 1'b0 || bus.pass_out.valid !== 1'b1 || {bus.pass_out.pc, bus.pass_out.ex_mem_out} !== exp) begin
            n_fail++; $display("FAIL alu_release: got s=%b v=%b pc=%h data=%h want pc=%h data=%h", bus.stall_o,
                               bus.pass_out.valid, bus.pass_out.pc, bus.pass_out.ex_mem_out, exp[63:32], exp[31:0]);
        end
        cyc();
        drive_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        for (int i = 0; i <= 5; i++) begin
            cyc();
            if (i < 5) begin
                res         = $urandom;
                bus.pass_in = mk_alu(32'h800 + 32'(4 * i), 5'(i + 10), res, 1'b0);
                exp_q.push_back({32'h800 + 32'(4 * i), res});
            end else begin
                bus.pass_in = '0;
            end
            if (i > 0) begin
                #3;
                exp = '1;
                if (exp_q.size() != 0) exp = exp_q.pop_front();
                n_tests++;
                if (bus.pass_out.valid !== 1'b1 || {bus.pass_out.pc, bus.pass_out.ex_mem_out} !== exp) begin
                    n_fail++; $display("FAIL b2b%0d: got v=%b pc=%h data=%h want pc=%h data=%h", i - 1,
                                       bus.pass_out.valid, bus.pass_out.pc, bus.pass_out.ex_mem_out, exp[63:32], exp[31:0]);
                end
            end
        end
        cyc();
        drive_idle();
    endtask

    task automatic test_reset_mid_load();
        cyc();
        bus.pass_in = mk_ld(32'h700, 32'h0000_5000, 1'b0, 2'd2);
        cyc();
        bus.pass_in = '0;
        bus.flush_i = 1'b1;
        cyc();
        bus.flush_i = 1'b0;
        bus.pass_in = mk_ld(32'h704, 32'h0000_5004, 1'b0, 2'd2);
        cyc();
        bus.pass_in = '0;
        #3;
        n_tests++;
        if (bus.stall_o !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_stall: got %b want 1", bus.stall_o);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.stall_o !== 1'b0 || bus.pass_out.valid !== 1'b0 ||
            {bus.fwd_valid, bus.fwd_rd, bus.fwd_data} !== 38'h0) begin
            n_fail++; $display("FAIL rst_mid_outputs: stall=%b valid=%b fwd=%b/%h/%h want all 0", bus.stall_o,
                               bus.pass_out.valid, bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
        end
        rst_n = 1'b1;
        cyc();
        bus.pass_in = mk_ld(32'h708, 32'h0000_5008, 1'b0, 2'd2);
        exp_q.push_back({32'h708, 32'h1357_9BDF});
        cyc();
        bus.pass_in   = '0;
        bus.dc_rvalid = 1'b1;
        bus.dc_rdata  = 32'h1357_9BDF;
        #3;
        exp = '1;
        if (exp_q.size() != 0) exp = exp_q.pop_front();
        n_tests++;
        if (bus.stall_o !== 1'b0 || bus.pass_out.valid !== 1'b1 || {bus.pass_out.pc, bus.pass_out.ex_mem_out} !== exp) begin
            n_fail++; $display("FAIL rst_post_load: got s=%b v=%b pc=%h data=%h want pc=%h data=%h", bus.stall_o,
                               bus.pass_out.valid, bus.pass_out.pc, bus.pass_out.ex_mem_out, exp[63:32], exp[31:0]);
        end
        cyc();
        drive_idle();
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        test_reset();
        test_ld_byte();
        test_load_align();
        test_hold();
        test_flush_drain();
        test_fwd();
        test_back_to_back();
        test_reset_mid_load();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_empty: %0d entries left want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
